egg_result_display: RTL and testbench

Downstream display stage for the egg-drop experiment CPU. It captures the register-file result taps (attempt count, broken count, last-broken flag) on an update strobe. It converts the two counts to BCD with a sequential double-dabble FSM and drives a multiplexed 8-digit active-low seven-segment display on the board.

---
 rtl/egg_result_display.sv | 215 +++++++++++++++++++++
 tb/tb_egg_result_display.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/egg_result_display.sv
// Captures attempt/broken/flag on in_update, converts both counts to BCD, drives 8-digit mux display.
// Latency: busy for 25 cycles after capture; display shows the new value from the 26th edge on.
// Backpressure: in_update is ignored while out_busy is high (not queued); scan never stalls.
//
// Ports:
//   in_clk, in_rst_n              clock, synchronous active-low reset
//   in_attempt_count[31:0]        attempt count (saturates to 9999 at capture)
//   in_broken_count[31:0]         broken count (saturates to 999 at capture)
//   in_is_last_broken             last-broken flag, shown on digit 0
//   in_update                     capture request, level-sampled in IDLE
//   out_busy                      conversion in progress
//   out_an[7:0]                   active-low digit enables, digit 7 leftmost
//   out_seg[7:0]                  active-low segments {dp,g,f,e,d,c,b,a}
module egg_result_display #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic [31:0] in_attempt_count,
  input  logic [31:0] in_broken_count,
  input  logic        in_is_last_broken,
  input  logic        in_update,
  output logic        out_busy,
  output logic [7:0]  out_an,
  output logic [7:0]  out_seg
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV_A = 2'd1,
    S_CONV_B = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  iter_cnt;

  // Double-dabble working registers: BCD accumulator and binary shift-out.
  logic [15:0] a_bcd;
  logic [13:0] a_bin;
  logic [11:0] b_bcd;
  logic [9:0]  b_bin;
  logic        cap_flag;
  logic        cap_sat_a;
  logic        cap_sat_b;

  // Display buffer; only written in DONE so the scan never sees a partial value.
  logic [15:0] buf_a;
  logic [11:0] buf_b;
  logic        buf_flag;
  logic        buf_sat_a;
  logic        buf_sat_b;

  logic        att_sat;
  logic        brk_sat;
  logic [15:0] a_adj;
  logic [11:0] b_adj;
  logic [29:0] a_shift;
  logic [21:0] b_shift;

  assign att_sat = (in_attempt_count > 32'd9999);
  assign brk_sat = (in_broken_count > 32'd999);

  // One double-dabble step: add 3 to each nibble >= 5, then shift the
  // combined {bcd, bin} register left by one.
  always_comb begin
    a_adj = a_bcd;
    b_adj = b_bcd;
    for (int i = 0; i < 4; i++) begin
      if (a_bcd[4*i +: 4] >= 4'd5) a_adj[4*i +: 4] = a_bcd[4*i +: 4] + 4'd3;
    end
    for (int i = 0; i < 3; i++) begin
      if (b_bcd[4*i +: 4] >= 4'd5) b_adj[4*i +: 4] = b_bcd[4*i +: 4] + 4'd3;
    end
    a_shift = {a_adj, a_bin} << 1;
    b_shift = {b_adj, b_bin} << 1;
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state     <= S_IDLE;
      iter_cnt  <= 4'd0;
      out_busy  <= 1'b0;
      a_bcd     <= 16'd0;
      a_bin     <= 14'd0;
      b_bcd     <= 12'd0;
      b_bin     <= 10'd0;
      cap_flag  <= 1'b0;
      cap_sat_a <= 1'b0;
      cap_sat_b <= 1'b0;
      buf_a     <= 16'd0;
      buf_b     <= 12'd0;
      buf_flag  <= 1'b0;
      buf_sat_a <= 1'b0;
      buf_sat_b <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_update) begin
            a_bin     <= att_sat ? 14'd9999 : in_attempt_count[13:0];
            b_bin     <= brk_sat ? 10'd999 : in_broken_count[9:0];
            a_bcd     <= 16'd0;
            b_bcd     <= 12'd0;
            cap_flag  <= in_is_last_broken;
            cap_sat_a <= att_sat;
            cap_sat_b <= brk_sat;
            iter_cnt  <= 4'd0;
            out_busy  <= 1'b1;
            state     <= S_CONV_A;
          end
        end
        S_CONV_A: begin
          a_bcd <= a_shift[29:14];
          a_bin <= a_shift[13:0];
          if (iter_cnt == 4'd13) begin
            iter_cnt <= 4'd0;
            state    <= S_CONV_B;
          end else begin
            iter_cnt <= iter_cnt + 4'd1;
          end
        end
        S_CONV_B: begin
          b_bcd <= b_shift[21:10];
          b_bin <= b_shift[9:0];
          if (iter_cnt == 4'd9) begin
            iter_cnt <= 4'd0;
            state    <= S_DONE;
          end else begin
            iter_cnt <= iter_cnt + 4'd1;
          end
        end
        S_DONE: begin
          buf_a     <= a_bcd;
          buf_b     <= b_bcd;
          buf_flag  <= cap_flag;
          buf_sat_a <= cap_sat_a;
          buf_sat_b <= cap_sat_b;
          out_busy  <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- scan
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       scan_idx;
  logic [3:0]       cur_digit;
  logic             cur_dp;
  logic [6:0]       cur_seg;

  always_comb begin
    cur_digit = 4'd0;
    cur_dp    = 1'b0;
    case (scan_idx)
      3'd0: cur_digit = {3'b000, buf_flag};
      3'd1: cur_digit = buf_b[3:0];
      3'd2: cur_digit = buf_b[7:4];
      3'd3: begin
        cur_digit = buf_b[11:8];
        cur_dp    = buf_sat_b;
      end
      3'd4: begin
        cur_digit = buf_a[3:0];
        cur_dp    = 1'b1;          // field separator between attempt and broken
      end
      3'd5: cur_digit = buf_a[7:4];
      3'd6: cur_digit = buf_a[11:8];
      3'd7: begin
        cur_digit = buf_a[15:12];
        cur_dp    = buf_sat_a;
      end
      default: cur_digit = 4'd0;
    endcase

    case (cur_digit)
      4'd0:    cur_seg = 7'h40;
      4'd1:    cur_seg = 7'h79;
      4'd2:    cur_seg = 7'h24;
      4'd3:    cur_seg = 7'h30;
      4'd4:    cur_seg = 7'h19;
      4'd5:    cur_seg = 7'h12;
      4'd6:    cur_seg = 7'h02;
      4'd7:    cur_seg = 7'h78;
      4'd8:    cur_seg = 7'h00;
      4'd9:    cur_seg = 7'h10;
      default: cur_seg = 7'h7F;    // blank; unreachable with valid BCD
    endcase
  end

  // Outputs are registered from the pre-edge index, so each digit is driven
  // for exactly SCAN_DIV cycles.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      div_cnt  <= '0;
      scan_idx <= 3'd0;
      out_an   <= 8'hFF;
      out_seg  <= 8'hFF;
    end else begin
      out_an  <= ~(8'd1 << scan_idx);
      out_seg <= {~cur_dp, cur_seg};
      if (div_cnt == DIV_LAST) begin
        div_cnt  <= '0;
        scan_idx <= scan_idx + 3'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_egg_result_display.sv
// Testbench for egg_result_display: two instances (SCAN_DIV=4 and 2) share stimulus.
// A decimal-arithmetic reference model predicts busy, digit enables and segments every cycle.
// Inputs change on negedge; outputs are compared on negedge.
module tb_egg_result_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] att;
  logic [31:0] brk;
  logic        flag;
  logic        upd;

  logic        busy4, busy2;
  logic [7:0]  an4, seg4, an2, seg2;

  always #5 clk = ~clk;

  egg_result_display #(.SCAN_DIV(4)) dut (
    .in_clk(clk), .in_rst_n(rst_n),
    .in_attempt_count(att), .in_broken_count(brk),
    .in_is_last_broken(flag), .in_update(upd),
    .out_busy(busy4), .out_an(an4), .out_seg(seg4)
  );

  egg_result_display #(.SCAN_DIV(2)) dut_s2 (
    .in_clk(clk), .in_rst_n(rst_n),
    .in_attempt_count(att), .in_broken_count(brk),
    .in_is_last_broken(flag), .in_update(upd),
    .out_busy(busy2), .out_an(an2), .out_seg(seg2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, want);
    end
  endtask

  // ------------------------------------------------------ reference model
  logic [6:0] seg_tbl [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int p10 [0:3] = '{1, 10, 100, 1000};

  bit   seen_rst = 1'b0;
  int   k;                 // edges since reset release
  int   busy_rem;          // cycles until the pending value becomes visible
  int   p_att, p_brk;
  bit   p_flag, p_sa, p_sb;
  int   d_att, d_brk;      // value currently in the display buffer
  bit   d_flag, d_sa, d_sb;
  logic [7:0] m_an4, m_seg4, m_an2, m_seg2;
  logic       m_busy;

  function automatic logic [7:0] exp_seg(input int d);
    int v;
    bit dp;
    if (d == 0)      v = d_flag ? 1 : 0;
    else if (d <= 3) v = (d_brk / p10[d-1]) % 10;
    else             v = (d_att / p10[d-4]) % 10;
    dp = (d == 4) || (d == 7 && d_sa) || (d == 3 && d_sb);
    return {~dp, seg_tbl[v]};
  endfunction

  always @(posedge clk) begin
    int i4, i2;
    if (!rst_n) begin
      seen_rst = 1'b1;
      k = 0; busy_rem = 0;
      d_att = 0; d_brk = 0; d_flag = 0; d_sa = 0; d_sb = 0;
      m_an4 = 8'hFF; m_seg4 = 8'hFF; m_an2 = 8'hFF; m_seg2 = 8'hFF;
      m_busy = 1'b0;
    end else begin
      k++;
      i4 = ((k - 1) / 4) % 8;
      i2 = ((k - 1) / 2) % 8;
      m_an4 = ~(8'd1 << i4); m_seg4 = exp_seg(i4);
      m_an2 = ~(8'd1 << i2); m_seg2 = exp_seg(i2);
      if (busy_rem > 0) begin
        busy_rem--;
        if (busy_rem == 0) begin
          d_att = p_att; d_brk = p_brk; d_flag = p_flag; d_sa = p_sa; d_sb = p_sb;
        end
      end else if (upd) begin
        p_sa   = (att > 32'd9999);
        p_sb   = (brk > 32'd999);
        p_att  = p_sa ? 9999 : int'(att);
        p_brk  = p_sb ? 999 : int'(brk);
        p_flag = flag;
        busy_rem = 25;
      end
      m_busy = (busy_rem > 0);
    end
  end

  always @(negedge clk) begin
    if (seen_rst) begin
      check("busy4", 32'(busy4), 32'(m_busy));
      check("busy2", 32'(busy2), 32'(m_busy));
      check("an4",   32'(an4),   32'(m_an4));
      check("seg4",  32'(seg4),  32'(m_seg4));
      check("an2",   32'(an2),   32'(m_an2));
      check("seg2",  32'(seg2),  32'(m_seg2));
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [31:0] a, input logic [31:0] b, input logic f);
    att = a; brk = b; flag = f; upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    cyc(n);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b0; upd = 1'b0; att = 32'd0; brk = 32'd0; flag = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(4);

    // Plain conversion, then a full frame on both instances.
    pulse(32'd1234, 32'd56, 1'b1);
    cyc(50);

    // Saturation of both fields.
    pulse(32'd20000, 32'd5000, 1'b0);
    cyc(50);

    // Request during conversion is dropped; earliest re-accept at t+26.
    pulse(32'd1234, 32'd56, 1'b1);      // returns at negedge after t
    cyc(9);
    pulse(32'd7, 32'd1, 1'b0);          // sampled at t+10, ignored
    cyc(15);
    pulse(32'd42, 32'd3, 1'b0);         // sampled at t+26, accepted
    cyc(50);

    // Reset at t+12 of a conversion discards it.
    pulse(32'd555, 32'd77, 1'b1);
    cyc(11);
    do_reset(2);
    cyc(40);

    // Boundary values right at and just past saturation.
    pulse(32'd9999, 32'd999, 1'b1);  cyc(40);
    pulse(32'd10000, 32'd1000, 1'b0); cyc(40);
    pulse(32'd0, 32'd0, 1'b0);        cyc(40);

    // Level-held request retriggers every 26 cycles.
    att = 32'd8080; brk = 32'd808; flag = 1'b1; upd = 1'b1;
    cyc(80);
    upd = 1'b0;
    cyc(30);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: ra = $urandom;
        1: ra = $urandom_range(9990, 10010);
        default: ra = $urandom_range(0, 9999);
      endcase
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = $urandom_range(990, 1010);
        default: rb = $urandom_range(0, 999);
      endcase
      pulse(ra, rb, 1'($urandom_range(0, 1)));
      cyc($urandom_range(1, 40));
      if ($urandom_range(0, 14) == 0) do_reset($urandom_range(1, 3));
    end
    cyc(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
